// File: rtl/t04_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package t04_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      D_ACC = 2'd1,
      I_ACC = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam logic [3:0]  SEL_ALL      = 4'hF;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/t04_mem_arbiter_starve_ctr.sv
// Saturating count of data grants made while a fetch is waiting.
// Latency: at_limit reflects the count registered at the previous edge.
// Backpressure: none; clr has priority over inc, and the count holds at LIMIT.
module t04_arb_starve_ctr #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic nrst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

   logic [W-1:0] cnt;

   // Clear on a fetch grant, otherwise count data grants up to LIMIT.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != W'(LIMIT))) begin
         cnt <= cnt + W'(1);
      end
   end

   assign at_limit = (cnt == W'(LIMIT));

endmodule

// File: rtl/t04_mem_arbiter.sv
// Arbitrates one external bus between instruction fetch and data load/store; data wins unless fetch is starved.
// Latency: strobe from the grant edge, port ack one edge after bus_ack, 3 cycles minimum between grants.
// Backpressure: requesters hold until their ack; bus strobes hold until bus_ack (watchdog with T04_ARB_TIMEOUT_EN).
module t04_mem_arbiter
   import t04_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
`ifdef T04_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT      = 255
`endif
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_sel,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              bus_read,
   output logic              bus_write,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [3:0]        bus_sel,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              busy
`ifdef T04_ARB_TIMEOUT_EN
   ,
   output logic              err
`endif
);

   arb_state_t state;
   arb_state_t state_nxt;

   logic d_pend;
   logic force_i;
   logic at_limit;
   logic grant_d;
   logic grant_i;
   logic acc_end;
   logic tmo;
   logic wd_hit;

   assign d_pend  = d_read | d_write;
   assign force_i = i_req & at_limit;
   assign busy    = (state != IDLE);

   t04_arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .nrst     (nrst),
      .inc      (grant_d & i_req),
      .clr      (grant_i),
      .at_limit (at_limit)
   );

`ifdef T04_ARB_TIMEOUT_EN
   logic [7:0] wd;

   // Watchdog: counts cycles spent waiting on the bus, restarts outside the access states.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wd <= 8'd0;
      end else if ((state == D_ACC) || (state == I_ACC)) begin
         wd <= wd + 8'd1;
      end else begin
         wd <= 8'd0;
      end
   end

   assign wd_hit = (wd == 8'(TIMEOUT - 1));
`else
   assign wd_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and grant/complete decisions; a real bus_ack always beats the watchdog.
   always_comb begin
      state_nxt = state;
      grant_d   = 1'b0;
      grant_i   = 1'b0;
      acc_end   = 1'b0;
      tmo       = 1'b0;
      case (state)
         IDLE: begin
            if (d_pend && !force_i) begin
               grant_d   = 1'b1;
               state_nxt = D_ACC;
            end else if (i_req) begin
               grant_i   = 1'b1;
               state_nxt = I_ACC;
            end
         end
         D_ACC, I_ACC: begin
            if (bus_ack) begin
               acc_end   = 1'b1;
               state_nxt = DONE;
            end else if (wd_hit) begin
               acc_end   = 1'b1;
               tmo       = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Bus request registers, returned data and one-cycle completion pulses.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         bus_read  <= 1'b0;
         bus_write <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_sel   <= 4'h0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
`ifdef T04_ARB_TIMEOUT_EN
         err       <= 1'b0;
`endif
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
`ifdef T04_ARB_TIMEOUT_EN
         err   <= 1'b0;
`endif
         if (grant_d) begin
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            bus_write <= d_write;
            bus_read  <= ~d_write;
            bus_sel   <= d_write ? d_sel : SEL_ALL;
         end
         if (grant_i) begin
            bus_addr  <= i_addr;
            bus_write <= 1'b0;
            bus_read  <= 1'b1;
            bus_sel   <= SEL_ALL;
         end
         if (acc_end) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
`ifdef T04_ARB_TIMEOUT_EN
            err       <= tmo;
`endif
            if (state == D_ACC) begin
               d_ack <= 1'b1;
               if (tmo) begin
                  d_rdata <= DATA_W'(TIMEOUT_DATA);
               end else if (!bus_write) begin
                  d_rdata <= bus_rdata;
               end
            end else begin
               i_ack   <= 1'b1;
               i_rdata <= tmo ? DATA_W'(TIMEOUT_DATA) : bus_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_t04_mem_arbiter.sv
// Self-checking bench for t04_mem_arbiter (timeout checks compile in with T04_ARB_TIMEOUT_EN).
// Latency: bus responder acks after a per-test number of cycles.
// Backpressure: requests are held until the matching ack, as a real core would.
module tb_t04_mem_arbiter;

   typedef struct {
      int          kind;      // 0 fetch, 1 load, 2 store, 3 load+store together
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          lat;
      bit          exp_is_d;
      bit          exp_wr;
      logic [3:0]  exp_sel;
   } vec_t;

   typedef struct {
      bit          is_d;
      logic [31:0] rdata;
   } sb_t;

   logic        clk = 1'b0;
   logic        nrst;
   logic        i_req, d_read, d_write;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_sel;
   logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
   logic        i_ack, d_ack, bus_read, bus_write, busy;
   logic [3:0]  bus_sel;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_ack   = 1'b0;
`ifdef T04_ARB_TIMEOUT_EN
   logic        err;
`endif

   int          n_chk  = 0;
   int          n_pass = 0;
   sb_t         sb_q[$];
   sb_t         sb_cur;
   int          bus_lat = 0;
   bit          bus_hang = 1'b0;
   bit          bus_unstable = 1'b0;
   int          bus_cnt = 0;
   logic [69:0] snap;
   logic [31:0] d_last = 32'h0;
   vec_t        tbl[6];

   always #5 clk = ~clk;

   t04_mem_arbiter #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .STARVE_LIMIT (4)
`ifdef T04_ARB_TIMEOUT_EN
      ,
      .TIMEOUT      (8)
`endif
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_ack     (i_ack),
      .d_read    (d_read),
      .d_write   (d_write),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_sel     (d_sel),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .bus_read  (bus_read),
      .bus_write (bus_write),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_sel   (bus_sel),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .busy      (busy)
`ifdef T04_ARB_TIMEOUT_EN
      ,
      .err       (err)
`endif
   );

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h00A0_0093;
         32'h0000_0200: return 32'h0000_0055;
         default:       return {a[15:0], ~a[15:0]};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic wait_strobe(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (bus_read || bus_write) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_ack(input bit is_d, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (is_d ? d_ack : i_ack) begin ok = 1'b1; break; end
      end
   endtask

   // Bus responder: acks after bus_lat cycles with data from the memory model, and
   // flags any change of the bus outputs while a strobe is held.
   always begin
      @(posedge clk); #1;
      if (nrst && (bus_read || bus_write) && !bus_hang) begin
         if (bus_cnt == 0) snap = {bus_read, bus_write, bus_addr, bus_sel, bus_wdata};
         else if (snap != {bus_read, bus_write, bus_addr, bus_sel, bus_wdata}) bus_unstable = 1'b1;
         if (bus_cnt >= bus_lat) begin
            bus_ack   = 1'b1;
            bus_rdata = mem_val(bus_addr);
         end else begin
            bus_ack = 1'b0;
         end
         bus_cnt++;
      end else begin
         bus_ack = 1'b0;
         bus_cnt = 0;
      end
   end

   // Scoreboard: every ack must match the oldest expected completion.
   always @(negedge clk) begin
      if (nrst && (i_ack || d_ack)) begin
         if (sb_q.size() == 0) begin
            chk("unexpected ack", 64'({i_ack, d_ack}), 64'(0));
         end else begin
            sb_cur = sb_q.pop_front();
            chk("ack port", 64'({i_ack, d_ack}), sb_cur.is_d ? 64'(2'b01) : 64'(2'b10));
            chk("ack rdata", sb_cur.is_d ? 64'(d_rdata) : 64'(i_rdata), 64'(sb_cur.rdata));
         end
      end
   end

   task automatic run_vec(input int idx, input vec_t v);
      bit  ok;
      sb_t e;
      bus_lat = v.lat;
      bus_hang = 1'b0;
      bus_unstable = 1'b0;
      @(posedge clk); #1;
      i_req   = (v.kind == 0);
      i_addr  = v.addr;
      d_read  = (v.kind == 1) || (v.kind == 3);
      d_write = (v.kind == 2) || (v.kind == 3);
      d_addr  = v.addr;
      d_wdata = v.wdata;
      d_sel   = v.sel;
      e.is_d  = v.exp_is_d;
      e.rdata = (v.exp_is_d && v.exp_wr) ? d_last : mem_val(v.addr);
      if (v.exp_is_d) d_last = e.rdata;
      sb_q.push_back(e);
      wait_strobe(ok);
      chk($sformatf("v%0d strobe seen", idx), 64'(ok), 64'(1));
      chk($sformatf("v%0d strobe kind", idx), 64'({bus_write, bus_read}), v.exp_wr ? 64'(2'b10) : 64'(2'b01));
      chk($sformatf("v%0d bus_addr", idx), 64'(bus_addr), 64'(v.addr));
      chk($sformatf("v%0d bus_sel", idx), 64'(bus_sel), 64'(v.exp_sel));
      if (v.exp_wr) chk($sformatf("v%0d bus_wdata", idx), 64'(bus_wdata), 64'(v.wdata));
      wait_ack(v.exp_is_d, ok);
      chk($sformatf("v%0d ack seen", idx), 64'(ok), 64'(1));
      i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d single ack then idle", idx), 64'({busy, i_ack, d_ack}), 64'(0));
      chk($sformatf("v%0d bus held stable", idx), 64'(bus_unstable), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      int cnt;
      int any_ack;
      sb_t e;

      tbl[0] = '{kind:0, addr:32'h100, wdata:32'h0,        sel:4'h0, lat:2, exp_is_d:1'b0, exp_wr:1'b0, exp_sel:4'hF};
      tbl[1] = '{kind:1, addr:32'h200, wdata:32'h0,        sel:4'h0, lat:0, exp_is_d:1'b1, exp_wr:1'b0, exp_sel:4'hF};
      tbl[2] = '{kind:2, addr:32'h300, wdata:32'h12345678, sel:4'h3, lat:1, exp_is_d:1'b1, exp_wr:1'b1, exp_sel:4'h3};
      tbl[3] = '{kind:3, addr:32'h304, wdata:32'hCAFEF00D, sel:4'hC, lat:3, exp_is_d:1'b1, exp_wr:1'b1, exp_sel:4'hC};
      tbl[4] = '{kind:1, addr:32'h3F0, wdata:32'h0,        sel:4'h0, lat:1, exp_is_d:1'b1, exp_wr:1'b0, exp_sel:4'hF};
      tbl[5] = '{kind:0, addr:32'h104, wdata:32'h0,        sel:4'h0, lat:0, exp_is_d:1'b0, exp_wr:1'b0, exp_sel:4'hF};

      i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
      i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_sel = 4'h0;

      // Asynchronous reset takes effect before any clock edge.
      nrst = 1'b1;
      #2 nrst = 1'b0;
      #1;
      chk("reset ctrl outputs", 64'({i_ack, d_ack, bus_read, bus_write, busy, bus_sel}), 64'(0));
      chk("reset rdata regs", 64'({i_rdata, d_rdata}), 64'(0));
      chk("reset bus addr/wdata", 64'({bus_addr, bus_wdata}), 64'(0));
      repeat (2) @(negedge clk);
      nrst = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

      // Fetch and load together: data first, fetch in the following IDLE.
      bus_lat = 1;
      @(posedge clk); #1;
      e.is_d = 1'b1; e.rdata = 32'h55;       sb_q.push_back(e);
      e.is_d = 1'b0; e.rdata = 32'h00A00093; sb_q.push_back(e);
      d_last = 32'h55;
      i_req = 1'b1; i_addr = 32'h100; d_read = 1'b1; d_addr = 32'h200;
      fork
         begin
            bit okd;
            wait_ack(1'b1, okd);
            chk("simul d_ack seen", 64'(okd), 64'(1));
            d_read = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("simul fetch granted next", 64'({bus_read, bus_addr}), 64'({1'b1, 32'h100}));
         end
         begin
            bit oki;
            wait_ack(1'b0, oki);
            chk("simul i_ack seen", 64'(oki), 64'(1));
            i_req = 1'b0;
         end
      join

      // Starvation: four data grants while fetch waits, then fetch, then the fifth.
      bus_lat = 0;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         e.is_d = 1'b1; e.rdata = mem_val(32'h400 + 32'(4 * k)); sb_q.push_back(e);
      end
      e.is_d = 1'b0; e.rdata = mem_val(32'h500); sb_q.push_back(e);
      e.is_d = 1'b1; e.rdata = mem_val(32'h410); sb_q.push_back(e);
      d_last = mem_val(32'h410);
      i_req = 1'b1; i_addr = 32'h500;
      fork
         begin
            bit okd;
            for (int k = 0; k < 5; k++) begin
               d_read = 1'b1;
               d_addr = 32'h400 + 32'(4 * k);
               wait_ack(1'b1, okd);
               chk($sformatf("starve d_ack %0d", k), 64'(okd), 64'(1));
               d_read = 1'b0;
               @(posedge clk); #1;
            end
         end
         begin
            bit oki;
            wait_ack(1'b0, oki);
            chk("starve i_ack seen", 64'(oki), 64'(1));
            i_req = 1'b0;
         end
      join

      // Reset during a data access: strobe drops at once, no completion afterwards.
      bus_hang = 1'b1;
      @(posedge clk); #1;
      d_read = 1'b1; d_addr = 32'h600;
      wait_strobe(ok);
      chk("midreset strobe seen", 64'(ok), 64'(1));
      nrst = 1'b0;
      #1;
      chk("midreset strobe drops", 64'({bus_read, bus_write, busy}), 64'(0));
      d_read = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      bus_hang = 1'b0;
      any_ack = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (i_ack || d_ack) any_ack++;
      end
      chk("midreset no ack after release", 64'(any_ack), 64'(0));

`ifdef T04_ARB_TIMEOUT_EN
      // Watchdog expiry with a silent bus.
      bus_hang = 1'b1;
      @(posedge clk); #1;
      e.is_d = 1'b1; e.rdata = 32'hDEADBEEF; sb_q.push_back(e);
      d_read = 1'b1; d_addr = 32'h700;
      wait_strobe(ok);
      chk("tmo strobe seen", 64'(ok), 64'(1));
      cnt = 0;
      while (bus_read && (cnt < 300)) begin
         cnt++;
         @(negedge clk);
      end
      chk("tmo strobe cycles", 64'(cnt), 64'(8));
      chk("tmo ack and err", 64'({d_ack, err}), 64'(2'b11));
      chk("tmo rdata", 64'(d_rdata), 64'(32'hDEADBEEF));
      d_read = 1'b0;
      @(negedge clk);
      chk("tmo err one cycle", 64'(err), 64'(0));
      bus_hang = 1'b0;
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 64'(sb_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
